// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle command front-end for the 16-bit combinational ALU
//
// Purpose:
//    Accepts one command per cmd_valid/cmd_ready handshake and drives one or
//    more operations into the combinational ALU. The ALU result and flags
//    from the last issued cycle are returned on the rsp_valid/rsp_ready
//    channel. MUL is repeated addition: alu_m accumulates, alu_n holds A,
//    and the step count is the low CNT_W bits of B.
//
// Optional feature macro: ALU_SEQ_OVF_EN
//    When defined, adds rsp_ovf. It is a sticky signed-overflow flag for every
//    ADD-map cycle of the current command and is cleared on command accept.
//
// Ports:
//    clk, rst_n                 clock, asynchronous active-low reset
//    cmd_valid/cmd_ready        command handshake (cmd_ready is 1 only in IDLE)
//    cmd_op, cmd_a, cmd_b       0=ADD 1=AND 2=OR 3=INC 4=MUL, 5..7 illegal
//    alu_m, alu_n, alu_opc      registered drive to the ALU inM/inN/opc
//    alu_f, alu_zer, alu_neg    combinational ALU result and flags
//    rsp_valid/rsp_ready        response handshake
//    rsp_data, rsp_zer, rsp_neg result and flags
//    rsp_err                    illegal opcode was issued
//    rsp_ovf                    (ALU_SEQ_OVF_EN only) signed overflow seen

module alu_op_sequencer #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   output logic [DATA_W-1:0] alu_m,
   output logic [DATA_W-1:0] alu_n,
   output logic [2:0]        alu_opc,
   input  logic [DATA_W-1:0] alu_f,
   input  logic              alu_zer,
   input  logic              alu_neg,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_zer,
   output logic              rsp_neg,
`ifdef ALU_SEQ_OVF_EN
   output logic              rsp_ovf,
`endif
   output logic              rsp_err
);

   // Command opcodes
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_AND = 3'd1;
   localparam logic [2:0] OP_OR  = 3'd2;
   localparam logic [2:0] OP_INC = 3'd3;
   localparam logic [2:0] OP_MUL = 3'd4;

   // ALU opcode map
   localparam logic [2:0] ALU_ADD = 3'b100;
   localparam logic [2:0] ALU_INC = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   logic             is_mul;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         is_mul    <= 1'b0;
         cnt       <= '0;
         cmd_ready <= 1'b1;
         alu_m     <= '0;
         alu_n     <= '0;
         alu_opc   <= ALU_ADD;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_zer   <= 1'b0;
         rsp_neg   <= 1'b0;
         rsp_err   <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
         rsp_ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  is_mul    <= 1'b0;
                  rsp_err   <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
                  rsp_ovf   <= 1'b0;
`endif
                  case (cmd_op)
                     OP_ADD, OP_AND, OP_OR, OP_INC: begin
                        alu_m <= cmd_a;
                        alu_n <= cmd_b;
                        case (cmd_op)
                           OP_AND:  alu_opc <= ALU_AND;
                           OP_OR:   alu_opc <= ALU_OR;
                           OP_INC:  alu_opc <= ALU_INC;
                           default: alu_opc <= ALU_ADD;
                        endcase
                        state <= S_EXEC;
                     end
                     OP_MUL: begin
                        if (cmd_b[CNT_W-1:0] == '0) begin
                           // Zero iterations: answer immediately, ALU stays idle.
                           rsp_valid <= 1'b1;
                           rsp_data  <= '0;
                           rsp_zer   <= 1'b1;
                           rsp_neg   <= 1'b0;
                           state     <= S_DONE;
                        end else begin
                           // Accumulate A into alu_m once per EXEC cycle.
                           alu_m   <= '0;
                           alu_n   <= cmd_a;
                           alu_opc <= ALU_ADD;
                           is_mul  <= 1'b1;
                           cnt     <= cmd_b[CNT_W-1:0];
                           state   <= S_EXEC;
                        end
                     end
                     default: begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        rsp_zer   <= 1'b0;
                        rsp_neg   <= 1'b0;
                        state     <= S_DONE;
                     end
                  endcase
               end
            end
            S_EXEC: begin
`ifdef ALU_SEQ_OVF_EN
               // Same-sign operands producing a different-sign sum.
               if (alu_opc == ALU_ADD &&
                   alu_m[DATA_W-1] == alu_n[DATA_W-1] &&
                   alu_f[DATA_W-1] != alu_m[DATA_W-1])
                  rsp_ovf <= 1'b1;
`endif
               if (!is_mul || cnt == CNT_W'(1)) begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= alu_f;
                  rsp_zer   <= alu_zer;
                  rsp_neg   <= alu_neg;
                  alu_m     <= '0;
                  alu_n     <= '0;
                  alu_opc   <= ALU_ADD;
                  state     <= S_DONE;
               end else begin
                  alu_m <= alu_f;
                  cnt   <= cnt - CNT_W'(1);
               end
            end
            S_DONE: begin
               // cmd_ready rises only after the handshake edge, so a new
               // command can never be taken in the same cycle.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer

module tb_alu_op_sequencer;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic [15:0] alu_m;
   logic [15:0] alu_n;
   logic [2:0]  alu_opc;
   logic [15:0] alu_f;
   logic        alu_zer;
   logic        alu_neg;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_zer;
   logic        rsp_neg;
   logic        rsp_err;
`ifdef ALU_SEQ_OVF_EN
   logic        rsp_ovf;
`endif

   int checks;
   int failures;

   alu_op_sequencer #(.DATA_W(16), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .alu_m     (alu_m),
      .alu_n     (alu_n),
      .alu_opc   (alu_opc),
      .alu_f     (alu_f),
      .alu_zer   (alu_zer),
      .alu_neg   (alu_neg),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_zer   (rsp_zer),
      .rsp_neg   (rsp_neg),
`ifdef ALU_SEQ_OVF_EN
      .rsp_ovf   (rsp_ovf),
`endif
      .rsp_err   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model of the combinational ALU.
   always_comb begin
      alu_f = 16'h0000;
      case (alu_opc)
         3'b100:  alu_f = alu_m + alu_n;
         3'b010:  alu_f = alu_m + 16'd1;
         3'b001:  alu_f = alu_m & alu_n;
         3'b101:  alu_f = alu_m | alu_n;
         default: alu_f = 16'h0000;
      endcase
      alu_zer = (alu_f == 16'h0000);
      alu_neg = alu_f[15];
   end

   // Presents one command; returns #1 after the accept edge.
   task automatic send_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   // Number of cycles after the accept edge until rsp_valid is seen; 999 on timeout.
   task automatic wait_rsp(output int lat);
      lat = 999;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic ack_rsp();
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 16'h0 ||
          rsp_zer !== 1'b0 || rsp_neg !== 1'b0 || rsp_err !== 1'b0 ||
          alu_opc !== 3'b100 || alu_m !== 16'h0 || alu_n !== 16'h0) begin
         failures++;
         $display("FAIL reset_state: rdy=%b vld=%b data=%h zer=%b neg=%b err=%b opc=%b m=%h n=%h required rdy=1 vld=0 data=0 flags=0 opc=100 m=0 n=0",
                  cmd_ready, rsp_valid, rsp_data, rsp_zer, rsp_neg, rsp_err, alu_opc, alu_m, alu_n);
      end
   endtask

   task automatic test_add();
      int lat;
      send_cmd(3'd0, 16'd5, 16'hFFF9);
      checks++;
      if (alu_opc !== 3'b100 || alu_m !== 16'd5 || alu_n !== 16'hFFF9 || cmd_ready !== 1'b0) begin
         failures++;
         $display("FAIL add_exec_drive: opc=%b m=%h n=%h rdy=%b required opc=100 m=0005 n=fff9 rdy=0",
                  alu_opc, alu_m, alu_n, cmd_ready);
      end
      wait_rsp(lat);
      checks++;
      if (lat !== 2 || rsp_data !== 16'hFFFE || rsp_neg !== 1'b1 || rsp_zer !== 1'b0 || rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL add_result: lat=%0d data=%h neg=%b zer=%b err=%b required lat=2 data=fffe neg=1 zer=0 err=0",
                  lat, rsp_data, rsp_neg, rsp_zer, rsp_err);
      end
      checks++;
      if (alu_opc !== 3'b100 || alu_m !== 16'h0 || alu_n !== 16'h0) begin
         failures++;
         $display("FAIL done_idle_drive: opc=%b m=%h n=%h required opc=100 m=0 n=0", alu_opc, alu_m, alu_n);
      end
      ack_rsp();
   endtask

   task automatic test_and_inc();
      int lat;
      send_cmd(3'd1, 16'hF0F0, 16'h0F0F);
      wait_rsp(lat);
      checks++;
      if (lat !== 2 || rsp_data !== 16'h0000 || rsp_zer !== 1'b1 || rsp_neg !== 1'b0) begin
         failures++;
         $display("FAIL and_result: lat=%0d data=%h zer=%b neg=%b required lat=2 data=0000 zer=1 neg=0",
                  lat, rsp_data, rsp_zer, rsp_neg);
      end
      ack_rsp();
      send_cmd(3'd3, 16'h7FFF, 16'h1234);
      wait_rsp(lat);
      checks++;
      if (lat !== 2 || rsp_data !== 16'h8000 || rsp_neg !== 1'b1 || rsp_zer !== 1'b0) begin
         failures++;
         $display("FAIL inc_result: lat=%0d data=%h neg=%b zer=%b required lat=2 data=8000 neg=1 zer=0",
                  lat, rsp_data, rsp_neg, rsp_zer);
      end
      ack_rsp();
      send_cmd(3'd2, 16'h1200, 16'h0034);
      wait_rsp(lat);
      checks++;
      if (lat !== 2 || rsp_data !== 16'h1234 || rsp_neg !== 1'b0 || rsp_zer !== 1'b0) begin
         failures++;
         $display("FAIL or_result: lat=%0d data=%h neg=%b zer=%b required lat=2 data=1234 neg=0 zer=0",
                  lat, rsp_data, rsp_neg, rsp_zer);
      end
      ack_rsp();
   endtask

   task automatic test_mul();
      int lat;
      send_cmd(3'd4, 16'd3, 16'd4);
      checks++;
      if (alu_m !== 16'h0 || alu_n !== 16'd3 || alu_opc !== 3'b100) begin
         failures++;
         $display("FAIL mul_first_drive: m=%h n=%h opc=%b required m=0000 n=0003 opc=100", alu_m, alu_n, alu_opc);
      end
      wait_rsp(lat);
      checks++;
      if (lat !== 5 || rsp_data !== 16'd12 || rsp_zer !== 1'b0 || rsp_neg !== 1'b0 || rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL mul_3x4: lat=%0d data=%h zer=%b neg=%b err=%b required lat=5 data=000c zer=0 neg=0 err=0",
                  lat, rsp_data, rsp_zer, rsp_neg, rsp_err);
      end
      ack_rsp();
      // -3 * 2 = -6, flags from the last addition.
      send_cmd(3'd4, 16'hFFFD, 16'h0302);
      wait_rsp(lat);
      checks++;
      if (lat !== 3 || rsp_data !== 16'hFFFA || rsp_neg !== 1'b1 || rsp_zer !== 1'b0) begin
         failures++;
         $display("FAIL mul_neg: lat=%0d data=%h neg=%b zer=%b required lat=3 data=fffa neg=1 zer=0",
                  lat, rsp_data, rsp_neg, rsp_zer);
      end
      ack_rsp();
      send_cmd(3'd4, 16'd9, 16'd0);
      wait_rsp(lat);
      checks++;
      if (lat !== 1 || rsp_data !== 16'h0 || rsp_zer !== 1'b1 || rsp_neg !== 1'b0 || rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL mul_count0: lat=%0d data=%h zer=%b neg=%b err=%b required lat=1 data=0000 zer=1 neg=0 err=0",
                  lat, rsp_data, rsp_zer, rsp_neg, rsp_err);
      end
      ack_rsp();
   endtask

   task automatic test_illegal_hold();
      int lat;
      send_cmd(3'd6, 16'h1111, 16'h2222);
      wait_rsp(lat);
      checks++;
      if (lat !== 1 || rsp_err !== 1'b1 || rsp_data !== 16'h0 || rsp_zer !== 1'b0 || rsp_neg !== 1'b0) begin
         failures++;
         $display("FAIL illegal_op: lat=%0d err=%b data=%h zer=%b neg=%b required lat=1 err=1 data=0000 zer=0 neg=0",
                  lat, rsp_err, rsp_data, rsp_zer, rsp_neg);
      end
      // A competing command must be ignored while the response is stalled.
      cmd_valid = 1'b1;
      cmd_op    = 3'd0;
      cmd_a     = 16'd1;
      cmd_b     = 16'd1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 16'h0 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold[%0d]: vld=%b err=%b data=%h rdy=%b required vld=1 err=1 data=0000 rdy=0",
                     i, rsp_valid, rsp_err, rsp_data, cmd_ready);
         end
      end
      cmd_valid = 1'b0;
      ack_rsp();
   endtask

   task automatic test_back_to_back();
      int lat;
      send_cmd(3'd0, 16'd2, 16'd3);
      wait_rsp(lat);
      checks++;
      if (lat !== 2 || rsp_data !== 16'd5) begin
         failures++;
         $display("FAIL b2b_first: lat=%0d data=%h required lat=2 data=0005", lat, rsp_data);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = 3'd1;
      cmd_a     = 16'hFFFF;
      cmd_b     = 16'h00FF;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_no_same_cycle_accept: vld=%b rdy=%b required vld=0 rdy=1", rsp_valid, cmd_ready);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      checks++;
      if (cmd_ready !== 1'b0 || alu_opc !== 3'b001 || alu_m !== 16'hFFFF) begin
         failures++;
         $display("FAIL b2b_accept_next: rdy=%b opc=%b m=%h required rdy=0 opc=001 m=ffff", cmd_ready, alu_opc, alu_m);
      end
      wait_rsp(lat);
      checks++;
      if (lat !== 2 || rsp_data !== 16'h00FF || rsp_zer !== 1'b0) begin
         failures++;
         $display("FAIL b2b_second: lat=%0d data=%h zer=%b required lat=2 data=00ff zer=0", lat, rsp_data, rsp_zer);
      end
      ack_rsp();
   endtask

   task automatic test_abort_reset();
      int lat;
      send_cmd(3'd4, 16'd2, 16'd10);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_zer !== 1'b0 ||
          rsp_neg !== 1'b0 || rsp_err !== 1'b0 || alu_opc !== 3'b100 || alu_m !== 16'h0 || alu_n !== 16'h0) begin
         failures++;
         $display("FAIL abort_reset_values: rdy=%b vld=%b data=%h zer=%b neg=%b err=%b opc=%b m=%h n=%h required reset values",
                  cmd_ready, rsp_valid, rsp_data, rsp_zer, rsp_neg, rsp_err, alu_opc, alu_m, alu_n);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_no_response[%0d]: vld=%b rdy=%b required vld=0 rdy=1", i, rsp_valid, cmd_ready);
         end
      end
      send_cmd(3'd0, 16'd1, 16'd1);
      wait_rsp(lat);
      checks++;
      if (lat !== 2 || rsp_data !== 16'd2 || rsp_zer !== 1'b0 || rsp_neg !== 1'b0) begin
         failures++;
         $display("FAIL after_abort_add: lat=%0d data=%h required lat=2 data=0002", lat, rsp_data);
      end
      ack_rsp();
   endtask

`ifdef ALU_SEQ_OVF_EN
   task automatic test_ovf();
      int lat;
      send_cmd(3'd0, 16'h7FFF, 16'h0001);
      wait_rsp(lat);
      checks++;
      if (rsp_data !== 16'h8000 || rsp_ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set: data=%h ovf=%b required data=8000 ovf=1", rsp_data, rsp_ovf);
      end
      ack_rsp();
      send_cmd(3'd0, 16'd1, 16'd1);
      wait_rsp(lat);
      checks++;
      if (rsp_data !== 16'd2 || rsp_ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clear: data=%h ovf=%b required data=0002 ovf=0", rsp_data, rsp_ovf);
      end
      ack_rsp();
   endtask
`endif

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_a     = 16'h0;
      cmd_b     = 16'h0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_add();
      test_and_inc();
      test_mul();
      test_illegal_hold();
      test_back_to_back();
      test_abort_reset();
`ifdef ALU_SEQ_OVF_EN
      test_ovf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
